// File: rtl/bias_relu_stage_layer1.sv
// Layer-1 bias + ReLU stage: loads the layer-1 biases once, then turns each
// accumulated dot-product vector into 8-bit saturated activations, one neuron per cycle.
module bias_relu_stage_layer1 #(
    parameter int unsigned OUT_SIZE   = 8,
    parameter int unsigned W          = 8,
    parameter int unsigned ACC_W      = 20,
    parameter int unsigned BIAS_SHIFT = 4,
    parameter int unsigned OUT_SHIFT  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      bias_start,
    input  logic                      bias_done,
    input  logic [OUT_SIZE*W-1:0]     bias_vec,
    input  logic                      acc_valid,
    input  logic [OUT_SIZE*ACC_W-1:0] acc_vec,
    output logic [OUT_SIZE*W-1:0]     act_out,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned IDX_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int unsigned SUM_W   = ACC_W + 1;
    localparam int unsigned ACT_MAX = (1 << (W - 1)) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_BIAS,
        S_WAIT_ACC,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        w_bias_start_nxt;

    logic                        r_bias_start;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_bias_loaded;
    logic [IDX_W-1:0]            r_idx;
    logic [OUT_SIZE*W-1:0]       r_bias;
    logic [OUT_SIZE*ACC_W-1:0]   r_acc;
    logic [OUT_SIZE*W-1:0]       r_act;

    logic signed [W-1:0]         w_bias_sel;
    logic signed [ACC_W-1:0]     w_acc_sel;
    logic signed [SUM_W-1:0]     w_bias_ext;
    logic signed [SUM_W-1:0]     w_sum;
    logic signed [SUM_W-1:0]     w_shift;
    logic [W-1:0]                w_act;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and loader trigger request
    always_comb begin
        w_state_nxt      = r_state;
        w_bias_start_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (r_bias_loaded) begin
                        w_state_nxt = S_WAIT_ACC;
                    end else begin
                        w_state_nxt      = S_LOAD_BIAS;
                        w_bias_start_nxt = 1'b1;
                    end
                end
            end
            S_LOAD_BIAS: begin
                if (bias_done) begin
                    w_state_nxt = S_WAIT_ACC;
                end
            end
            S_WAIT_ACC: begin
                if (acc_valid) begin
                    w_state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (r_idx == IDX_W'(OUT_SIZE - 1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake outputs registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bias_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_bias_start <= w_bias_start_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    // Per-neuron bias alignment, rescale and saturating ReLU
    always_comb begin
        w_bias_sel = r_bias[r_idx*W +: W];
        w_acc_sel  = r_acc[r_idx*ACC_W +: ACC_W];
        w_bias_ext = SUM_W'(w_bias_sel) <<< BIAS_SHIFT;
        w_sum      = SUM_W'(w_acc_sel) + w_bias_ext;
        w_shift    = w_sum >>> OUT_SHIFT;
        if (w_shift[SUM_W-1]) begin
            w_act = '0;
        end else if (w_shift > $signed(SUM_W'(ACT_MAX))) begin
            w_act = W'(ACT_MAX);
        end else begin
            w_act = w_shift[W-1:0];
        end
    end

    // Bias/accumulator capture, neuron index and activation write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bias        <= '0;
            r_bias_loaded <= 1'b0;
            r_acc         <= '0;
            r_idx         <= '0;
            r_act         <= '0;
        end else begin
            case (r_state)
                S_LOAD_BIAS: begin
                    if (bias_done) begin
                        r_bias        <= bias_vec;
                        r_bias_loaded <= 1'b1;
                    end
                end
                S_WAIT_ACC: begin
                    if (acc_valid) begin
                        r_acc <= acc_vec;
                        r_idx <= '0;
                    end
                end
                S_COMPUTE: begin
                    r_act[r_idx*W +: W] <= w_act;
                    r_idx               <= r_idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bias_start = r_bias_start;
    assign busy       = r_busy;
    assign done       = r_done;
    assign act_out    = r_act;

endmodule

// File: tb/tb_bias_relu_stage_layer1.sv
// Self-checking bench for bias_relu_stage_layer1 against an arithmetic reference model.
module tb_bias_relu_stage_layer1;

    localparam int unsigned OUT_SIZE = 8;
    localparam int unsigned W        = 8;
    localparam int unsigned ACC_W    = 20;
    localparam int unsigned BV_W     = OUT_SIZE * W;
    localparam int unsigned AV_W     = OUT_SIZE * ACC_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            bias_start;
    logic            bias_done;
    logic [BV_W-1:0] bias_vec;
    logic            acc_valid;
    logic [AV_W-1:0] acc_vec;
    logic [BV_W-1:0] act_out;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;
    int bs_cnt = 0;
    int done_cnt = 0;

    logic [BV_W-1:0] exp_act;
    logic [BV_W-1:0] cur_bias;

    bias_relu_stage_layer1 #(
        .OUT_SIZE(OUT_SIZE), .W(W), .ACC_W(ACC_W), .BIAS_SHIFT(4), .OUT_SHIFT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias_start(bias_start),
        .bias_done(bias_done), .bias_vec(bias_vec), .acc_valid(acc_valid),
        .acc_vec(acc_vec), .act_out(act_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Pulse counters (read pre-update values at the edge)
    always @(posedge clk) begin
        if (bias_start) bs_cnt++;
        if (done) done_cnt++;
    end

    // Reference: bias*16 + acc, floor-divide by 16, clamp to 0..127
    function automatic logic [W-1:0] ref_act(input logic [W-1:0] b, input logic [ACC_W-1:0] a);
        longint bi, ai, sum, q;
        bi  = longint'($signed(b)) * 16;
        ai  = longint'($signed(a));
        sum = ai + bi;
        if (sum >= 0) q = sum / 16;
        else          q = -((-sum + 15) / 16);
        if (q < 0)   return '0;
        if (q > 127) return 8'd127;
        return W'(q);
    endfunction

    function automatic logic [BV_W-1:0] ref_vec(input logic [BV_W-1:0] bv, input logic [AV_W-1:0] av);
        logic [BV_W-1:0] r;
        r = '0;
        for (int i = 0; i < OUT_SIZE; i++)
            r[i*W +: W] = ref_act(bv[i*W +: W], av[i*ACC_W +: ACC_W]);
        return r;
    endfunction

    function automatic logic [BV_W-1:0] rand_bias();
        return BV_W'({$urandom(), $urandom()});
    endfunction

    function automatic logic [AV_W-1:0] rand_accs();
        logic [AV_W-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < OUT_SIZE; i++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 4000)) - 2000;
                1:       v = int'($urandom_range(0, 1048575)) - 524288;
                default: v = int'($urandom_range(0, 2400)) - 400;
            endcase
            r[i*ACC_W +: ACC_W] = ACC_W'(v);
        end
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; bias_done = 1'b0; acc_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_act = '0;
    endtask

    // Drives one start..done transaction and reports what it observed
    task automatic run_op(input logic [BV_W-1:0] bv, input logic [AV_W-1:0] av,
                          input bit cold, input bit hold_acc, input bit lb_pulse, input bit poke_start,
                          output bit bs_seen, output bit busy0, output bit held_wait,
                          output int lat_start, output int lat_cap,
                          output bit done_one, output bit idle_after);
        int n;
        int cap_n;
        bias_vec  = bv;
        acc_vec   = av;
        acc_valid = hold_acc;
        held_wait = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        bs_seen = bias_start;
        busy0   = busy;
        if (cold) begin
            if (lb_pulse) begin
                acc_valid = 1'b1; acc_vec = ~av;
                @(negedge clk); n++;
                acc_valid = 1'b0; acc_vec = av;
            end
            repeat (2) begin @(negedge clk); n++; end
            bias_done = 1'b1;
            @(negedge clk); n++;
            if (lb_pulse) begin
                repeat (3) begin
                    @(negedge clk); n++;
                    held_wait = held_wait & busy & !done;
                end
            end
        end
        if (hold_acc) begin
            cap_n = n + 1;
        end else begin
            acc_valid = 1'b1;
            @(negedge clk); n++;
            acc_valid = 1'b0;
            cap_n = n;
        end
        lat_start = -1;
        lat_cap   = -1;
        for (int m = 0; m < 40; m++) begin
            start = poke_start && (m == 2);
            @(negedge clk); n++;
            if (done) begin
                lat_start = n;
                lat_cap   = n - cap_n;
                break;
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_one   = !done;
        idle_after = !busy;
        acc_valid  = 1'b0;
        @(negedge clk);
        idle_after = idle_after & !busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; bias_done = 1'b0; acc_valid = 1'b0;
        bias_vec = '0; acc_vec = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({bias_start, busy, done} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 000", {bias_start, busy, done});
        end
        total++;
        if (act_out !== '0) begin
            bad++; $display("FAIL reset_act: got %h want 0", act_out);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bias_start, busy, done} !== 3'b000) begin
            bad++; $display("FAIL reset_idle: got %b want 000", {bias_start, busy, done});
        end
        exp_act = '0;
    endtask

    task automatic test_cold_run();
        logic [BV_W-1:0] bv;
        logic [AV_W-1:0] av;
        logic [BV_W-1:0] want;
        bit bs_seen, busy0, hw, d1, idle;
        int ls, lc, bs0;
        bv = {OUT_SIZE{8'h10}};
        av = '0;
        want = {OUT_SIZE{8'h10}};
        bs0 = bs_cnt;
        run_op(bv, av, 1'b1, 1'b0, 1'b0, 1'b0, bs_seen, busy0, hw, ls, lc, d1, idle);
        cur_bias = bv;
        exp_act = ref_vec(bv, av);
        total++;
        if (bs_seen !== 1'b1) begin bad++; $display("FAIL cold_bias_start: got %b want 1", bs_seen); end
        total++;
        if (bs_cnt - bs0 != 1) begin bad++; $display("FAIL cold_bias_start_count: got %0d want 1", bs_cnt - bs0); end
        total++;
        if (busy0 !== 1'b1) begin bad++; $display("FAIL cold_busy_rise: got %b want 1", busy0); end
        total++;
        if (lc != OUT_SIZE) begin bad++; $display("FAIL cold_latency: got %0d want %0d", lc, OUT_SIZE); end
        total++;
        if (act_out !== want) begin bad++; $display("FAIL cold_act: got %h want %h", act_out, want); end
        total++;
        if (act_out !== exp_act) begin bad++; $display("FAIL cold_model: got %h want %h", act_out, exp_act); end
        total++;
        if (!(d1 && idle)) begin bad++; $display("FAIL cold_done_pulse: got one=%b idle=%b want 1 1", d1, idle); end
    endtask

    task automatic test_neg_clamp();
        logic [BV_W-1:0] bv;
        logic [AV_W-1:0] av;
        bit bs_seen, busy0, hw, d1, idle;
        int ls, lc;
        do_reset();
        bv = {OUT_SIZE{8'hF0}};
        av = {OUT_SIZE{20'd100}};
        run_op(bv, av, 1'b1, 1'b0, 1'b0, 1'b0, bs_seen, busy0, hw, ls, lc, d1, idle);
        cur_bias = bv;
        exp_act = ref_vec(bv, av);
        total++;
        if (act_out !== '0) begin bad++; $display("FAIL neg_clamp: got %h want 0", act_out); end
        total++;
        if (bs_seen !== 1'b1) begin bad++; $display("FAIL neg_reload: got %b want 1", bs_seen); end
    endtask

    task automatic test_saturation();
        logic [BV_W-1:0] bv;
        logic [AV_W-1:0] av;
        bit bs_seen, busy0, hw, d1, idle;
        int ls, lc;
        do_reset();
        bv = rand_bias();
        av = rand_accs();
        bv[3*W +: W] = 8'h7F;
        bv[5*W +: W] = 8'h01;
        av[3*ACC_W +: ACC_W] = 20'd524287;
        av[5*ACC_W +: ACC_W] = 20'd40;
        run_op(bv, av, 1'b1, 1'b0, 1'b0, 1'b0, bs_seen, busy0, hw, ls, lc, d1, idle);
        cur_bias = bv;
        exp_act = ref_vec(bv, av);
        total++;
        if (act_out[3*W +: W] !== 8'h7F) begin bad++; $display("FAIL sat_hi: got %h want 7f", act_out[3*W +: W]); end
        total++;
        if (act_out[5*W +: W] !== 8'h03) begin bad++; $display("FAIL sat_mid: got %h want 03", act_out[5*W +: W]); end
        total++;
        if (act_out !== exp_act) begin bad++; $display("FAIL sat_model: got %h want %h", act_out, exp_act); end
    endtask

    task automatic test_warm_rerun();
        logic [AV_W-1:0] av;
        bit bs_seen, busy0, hw, d1, idle;
        int ls, lc, bs0;
        av = rand_accs();
        bs0 = bs_cnt;
        run_op(rand_bias(), av, 1'b0, 1'b1, 1'b0, 1'b0, bs_seen, busy0, hw, ls, lc, d1, idle);
        exp_act = ref_vec(cur_bias, av);
        total++;
        if (bs_cnt != bs0) begin bad++; $display("FAIL warm_no_bias_start: got %0d want 0", bs_cnt - bs0); end
        total++;
        if (busy0 !== 1'b1) begin bad++; $display("FAIL warm_busy_rise: got %b want 1", busy0); end
        total++;
        if (ls != OUT_SIZE + 2) begin bad++; $display("FAIL warm_latency: got %0d want %0d", ls, OUT_SIZE + 2); end
        total++;
        if (act_out !== exp_act) begin bad++; $display("FAIL warm_model: got %h want %h", act_out, exp_act); end
        total++;
        if (!(d1 && idle)) begin bad++; $display("FAIL warm_start_in_done: got one=%b idle=%b want 1 1", d1, idle); end
    endtask

    task automatic test_back_to_back();
        logic [AV_W-1:0] av;
        bit bs_seen, busy0, hw, d1, idle, hold, poke;
        int ls, lc, bs0;
        bs0 = bs_cnt;
        for (int k = 0; k < 6; k++) begin
            av   = rand_accs();
            hold = (k % 2) == 0;
            poke = (k % 3) == 1;
            run_op(rand_bias(), av, 1'b0, hold, 1'b0, poke, bs_seen, busy0, hw, ls, lc, d1, idle);
            exp_act = ref_vec(cur_bias, av);
            total++;
            if (act_out !== exp_act) begin bad++; $display("FAIL b2b_model[%0d]: got %h want %h", k, act_out, exp_act); end
            total++;
            if (lc != OUT_SIZE) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", k, lc, OUT_SIZE); end
            total++;
            if (!(d1 && idle)) begin bad++; $display("FAIL b2b_idle[%0d]: got one=%b idle=%b want 1 1", k, d1, idle); end
        end
        total++;
        if (bs_cnt != bs0) begin bad++; $display("FAIL b2b_no_bias_start: got %0d want 0", bs_cnt - bs0); end
    endtask

    task automatic test_acc_during_load();
        logic [BV_W-1:0] bv;
        logic [AV_W-1:0] av;
        bit bs_seen, busy0, hw, d1, idle;
        int ls, lc;
        do_reset();
        bv = rand_bias();
        av = rand_accs();
        run_op(bv, av, 1'b1, 1'b0, 1'b1, 1'b0, bs_seen, busy0, hw, ls, lc, d1, idle);
        cur_bias = bv;
        exp_act = ref_vec(bv, av);
        total++;
        if (hw !== 1'b1) begin bad++; $display("FAIL load_acc_waits: got %b want 1", hw); end
        total++;
        if (lc != OUT_SIZE) begin bad++; $display("FAIL load_acc_latency: got %0d want %0d", lc, OUT_SIZE); end
        total++;
        if (act_out !== exp_act) begin bad++; $display("FAIL load_acc_model: got %h want %h", act_out, exp_act); end
    endtask

    task automatic test_reset_mid();
        logic [AV_W-1:0] av;
        logic [BV_W-1:0] newv, part, bv;
        bit bs_seen, busy0, hw, d1, idle;
        int ls, lc, d0;
        av = rand_accs();
        newv = ref_vec(cur_bias, av);
        part = exp_act;
        for (int i = 0; i < 3; i++) part[i*W +: W] = newv[i*W +: W];
        acc_vec = av; acc_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (act_out !== part) begin bad++; $display("FAIL mid_partial: got %h want %h", act_out, part); end
        total++;
        if ({busy, done} !== 2'b10) begin bad++; $display("FAIL mid_busy: got %b want 10", {busy, done}); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bias_start, busy, done} !== 3'b000 || act_out !== '0) begin
            bad++; $display("FAIL mid_reset: got ctrl=%b act=%h want 000 0", {bias_start, busy, done}, act_out);
        end
        acc_valid = 1'b0; bias_done = 1'b0;
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt != d0) begin bad++; $display("FAIL mid_no_done: got %0d want 0", done_cnt - d0); end
        exp_act = '0;
        bv = rand_bias();
        av = rand_accs();
        run_op(bv, av, 1'b1, 1'b0, 1'b0, 1'b0, bs_seen, busy0, hw, ls, lc, d1, idle);
        cur_bias = bv;
        exp_act = ref_vec(bv, av);
        total++;
        if (bs_seen !== 1'b1) begin bad++; $display("FAIL mid_reload: got %b want 1", bs_seen); end
        total++;
        if (act_out !== exp_act) begin bad++; $display("FAIL mid_rerun_model: got %h want %h", act_out, exp_act); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_run();
        test_neg_clamp();
        test_saturation();
        test_warm_rerun();
        test_back_to_back();
        test_acc_during_load();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bias_relu_stage_layer1.md
# bias_relu_stage_layer1

- Sits directly downstream of the layer-1 bias loader.
- Triggers that loader once and captures its flat bias vector.
- Takes the layer-1 accumulated dot products, adds the aligned biases and rescales.
- Applies ReLU with saturation and produces the 8-bit activation vector consumed by layer 2.
- Processes one neuron per cycle, sequenced by a small FSM with a start/done handshake.

## Interface
- OUT_SIZE, 8, neurons in layer 1 (matches loader TOTAL_WEIGHTS)
- W, 8, bias and activation width (bias signed two's complement)
- ACC_W, 20, signed accumulator width per neuron
- BIAS_SHIFT, 4, left shift aligning bias to accumulator fixed point
- OUT_SHIFT, 4, arithmetic right shift applied to the biased sum
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to process one accumulator vector
- bias_start  out  1  one-cycle pulse to the bias loader's start
- bias_done  in  1  loader done (level, stays high once loaded)
- bias_vec  in  OUT_SIZE*W  flat bias vector, neuron i at [i*W +: W]
- acc_valid  in  1  acc_vec holds a valid vector this cycle
- acc_vec  in  OUT_SIZE*ACC_W  flat signed accumulators, neuron i at [i*ACC_W +: ACC_W]
- act_out  out  OUT_SIZE*W  activations, neuron i at [i*W +: W], range 0..127
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when act_out is complete

## Operation
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - bias_start, busy, done, act_out, internal bias/acc registers, index and bias_loaded all go to 0.
- States: IDLE, LOAD_BIAS, WAIT_ACC, COMPUTE, DONE.
- IDLE:
  - On start=1 with bias_loaded=0: pulse bias_start for exactly one cycle, go LOAD_BIAS.
  - On start=1 with bias_loaded=1: go WAIT_ACC; bias_start stays 0.
- LOAD_BIAS: when bias_done=1, copy bias_vec into the bias register, set bias_loaded=1, go WAIT_ACC.
- WAIT_ACC: when acc_valid=1, copy acc_vec into the acc register, set idx=0, go COMPUTE.
- COMPUTE, for neuron idx:
  - b = sign-extend(bias[idx]) <<< BIAS_SHIFT.
  - sum = acc[idx] + b, computed at ACC_W+1 bits signed with no overflow.
  - s = sum >>> OUT_SHIFT.
  - act = 0 if s<0; 127 if s>127; else s[W-1:0].
  - Write act into act_out[idx*W +: W].
  - If idx=OUT_SIZE-1 go DONE, else idx+1.
- DONE: done=1 for this one cycle, then IDLE.
- act_out:
  - Holds its value until overwritten slice-by-slice in the next COMPUTE.
  - Slices not yet rewritten keep their previous-run values.
- start is ignored when not in IDLE.
- acc_valid is ignored outside WAIT_ACC.
- bias_done is ignored outside LOAD_BIAS.
- Biases are loaded once per reset. bias_loaded is cleared only by rst_n.
- Reset mid-operation, any state: immediate return to IDLE with all outputs 0, and no done pulse. The next start reloads biases.

## Timing
- Edge numbering: start sampled at edge 0.
  - bias_start is high in the cycle after edge 0, i.e. registered at edge 0.
  - From IDLE, busy rises at edge 0.
- LOAD_BIAS → WAIT_ACC on the first edge where bias_done=1 is sampled.
- WAIT_ACC → COMPUTE on the edge sampling acc_valid=1.
- Neuron i is written at the (i+1)th edge after entering COMPUTE.
- Cycle counts:
  - COMPUTE lasts exactly OUT_SIZE cycles.
  - done is high for one cycle after the last write.
  - busy falls on the edge leaving DONE.
- Warm path (bias_loaded=1, acc_valid already high): done is high OUT_SIZE+2 cycles after the start edge.
  - One edge for IDLE→WAIT_ACC.
  - One edge for the WAIT_ACC capture.
  - OUT_SIZE edges of COMPUTE, ending in DONE.
- Back-to-back operation: a start in the cycle done is high is ignored. start is accepted from the following cycle, once the block is in IDLE.

## Test plan
- Cold run: bias_vec all 0x10, acc all 0 → exactly one bias_start pulse; after bias_done then acc_valid, act_out all 0x10; done one cycle, 8 cycles after the capture edge.
- Negative clamp: bias[i]=0xF0, acc[i]=100 → sum=-156, s=-10 → act 0x00 for all neurons.
- Saturation:
  - acc[3]=524287 with bias 0x7F → act[3]=0x7F.
  - acc[5]=40, bias 0x01 → sum 56, s=3 → act[5]=0x03.
- Warm rerun: second start after the first done → no bias_start pulse, no wait on bias_done; done exactly OUT_SIZE+2 cycles after start with acc_valid held high.
- Protocol:
  - start pulsed during COMPUTE → ignored.
  - acc_valid pulsed during LOAD_BIAS → not captured; the block still waits for a later acc_valid.
  - start in the done cycle → ignored.
- Reset mid-COMPUTE:
  - Drop rst_n after 3 neurons are written → act_out=0, busy=0, no done.
  - Next start → bias_start pulses again.
